// File: rtl/pwm_peripheral.sv
// 16-channel output stage: each channel forced low, held high, or driven by a shared 8-bit PWM.
// The duty value is shadowed and reloaded only at the period boundary.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_DIV - 1);

  logic [PreW-1:0] r_pre;
  logic [7:0]      r_cnt;
  logic [7:0]      r_duty;
  logic [15:0]     r_out;
  logic            r_period_start;

  logic            w_tick;
  logic            w_wrap;
  logic [7:0]      w_cnt_d;
  logic [7:0]      w_duty_d;
  logic            w_pwm_d;
  logic [15:0]     w_en_out;
  logic [15:0]     w_en_pwm;
  logic [15:0]     w_out_d;

  // The PWM level is evaluated on next-state counter/duty so the registered output
  // rises in the same cycle that period_start is asserted.
  always_comb begin
    w_tick   = (r_pre == PreMax);
    w_wrap   = w_tick && (r_cnt == 8'hFF);
    w_cnt_d  = w_tick ? r_cnt + 8'd1 : r_cnt;
    w_duty_d = w_wrap ? pwm_duty_cycle : r_duty;
    w_pwm_d  = (w_duty_d == 8'hFF) || (w_cnt_d < w_duty_d);
    w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    w_out_d  = w_en_out & (~w_en_pwm | {16{w_pwm_d}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre          <= '0;
      r_cnt          <= 8'h00;
      r_duty         <= 8'h00;
      r_out          <= 16'h0000;
      r_period_start <= 1'b0;
    end else begin
      r_pre          <= w_tick ? '0 : r_pre + PreW'(1);
      r_cnt          <= w_cnt_d;
      r_duty         <= w_duty_d;
      r_out          <= w_out_d;
      r_period_start <= w_wrap;
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: enable/mode vector table plus period/high-time
// sequences for duty extremes, boundary duty capture and asynchronous reset.
module tb_pwm_peripheral;

  logic        clk;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  pwm_peripheral #(.CLK_DIV(13)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_out[7:0]),
    .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0 (en_pwm[7:0]),
    .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle (pwm_duty_cycle),
    .out            (out),
    .period_start   (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] exp_out;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_ps();
    int waited;
    waited = 0;
    while (!period_start && waited < 5000) begin
      step(1);
      waited++;
    end
  endtask

  // Called on a sample where period_start is high; returns at the next one.
  task automatic measure(input int chg_at, input logic [7:0] chg_val,
                         output int per, output int hi, output int lo);
    per = 0;
    hi  = 0;
    lo  = 0;
    do begin
      if (per == chg_at) pwm_duty_cycle = chg_val;
      if (out == 16'hFFFF) hi++;
      else if (out == 16'h0000) lo++;
      per++;
      step(1);
    end while (!period_start && per < 5000);
  endtask

  initial begin
    vec_t vecs[8];
    int   per, hi, lo, bad;

    vecs[0] = '{16'h00FF, 16'h0000, 16'h00FF};
    vecs[1] = '{16'hFF00, 16'h0000, 16'hFF00};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[3] = '{16'h0000, 16'hFFFF, 16'h0000};
    vecs[4] = '{16'hFFFF, 16'h00FF, 16'hFF00};
    vecs[5] = '{16'hA5A5, 16'h0F0F, 16'hA0A0};
    vecs[6] = '{16'h1234, 16'h0000, 16'h1234};
    vecs[7] = '{16'hFFFF, 16'h8001, 16'h7FFE};

    rst_n          = 1'b0;
    en_out         = 16'hFFFF;
    en_pwm         = 16'hFFFF;
    pwm_duty_cycle = 8'h80;
    step(3);
    check("reset_out", 32'(out), 32'h0);
    check("reset_period_start", 32'(period_start), 32'h0);

    rst_n = 1'b1;
    cyc   = 0;
    bad   = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (out != 16'h0000 || period_start) bad++;
    end
    check("pre_wrap_quiet", 32'(bad), 32'h0);

    // duty_q is still 0 here, so PWM-mode channels read as low.
    for (int i = 0; i < 8; i++) begin
      en_out = vecs[i].en_out;
      en_pwm = vecs[i].en_pwm;
      step(1);
      check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
    end

    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    wait_ps();
    check("first_period_start_cycle", 32'(cyc), 32'd3328);

    measure(-1, 8'h00, per, hi, lo);
    check("p0_period", 32'(per), 32'd3328);
    check("p0_high", 32'(hi), 32'd1664);
    check("p0_low", 32'(lo), 32'd1664);

    measure(0, 8'h00, per, hi, lo);
    check("p1_high_old_duty", 32'(hi), 32'd1664);

    measure(0, 8'hFF, per, hi, lo);
    check("p2_duty00_high", 32'(hi), 32'd0);
    check("p2_duty00_low", 32'(lo), 32'd3328);

    measure(0, 8'h01, per, hi, lo);
    check("p3_dutyFF_high", 32'(hi), 32'd3328);
    check("p3_period", 32'(per), 32'd3328);

    // Decoy value for most of the period; the write on the wrap cycle must win.
    pwm_duty_cycle = 8'h77;
    measure(3327, 8'h40, per, hi, lo);
    check("p4_duty01_high", 32'(hi), 32'd13);

    measure(416, 8'hC0, per, hi, lo);
    check("p5_midchange_high", 32'(hi), 32'd832);

    measure(-1, 8'h00, per, hi, lo);
    check("p6_dutyC0_high", 32'(hi), 32'd2496);

    // Restore C0 so the post-reset reload is distinguishable from 0x00.
    pwm_duty_cycle = 8'hC0;
    step(1040);
    check("pre_reset_high", 32'(out), 32'hFFFF);
    rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'(out), 32'h0);
    check("async_reset_ps", 32'(period_start), 32'h0);
    step(2);
    rst_n = 1'b1;
    cyc   = 0;
    wait_ps();
    check("post_reset_ps_cycle", 32'(cyc), 32'd3328);
    measure(-1, 8'h00, per, hi, lo);
    check("post_reset_high", 32'(hi), 32'd2496);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Output stage directly downstream of the SPI register block. Consumes the five configuration registers it exposes (output enables, PWM enables, duty cycle) and drives 16 user outputs, each forced low, held high, or driven by a shared 8-bit PWM waveform. All channels share one PWM counter and one duty value. The duty value is shadow-buffered so that changes take effect only at a period boundary.

## Interface
Parameters:
- CLK_DIV, 13: clk cycles per PWM counter step, legal range ≥1. Default gives ≈3.0 kHz PWM from 10 MHz clk.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en_reg_out_7_0  input  8  output enable, channels 7..0
- en_reg_out_15_8  input  8  output enable, channels 15..8
- en_reg_pwm_7_0  input  8  PWM-mode select, channels 7..0
- en_reg_pwm_15_8  input  8  PWM-mode select, channels 15..8
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- out  output  16  channel outputs; bit i = channel i
- period_start  output  1  one-cycle pulse at each PWM period start

Inputs are synchronous to clk (the register block runs on clk); no synchronizers.

## Operation
- Prescaler: counter `pre`, width clog2(CLK_DIV) (min 1), counts 0..CLK_DIV-1 and wraps. `tick` = (pre == CLK_DIV-1). With CLK_DIV=1, tick is asserted every cycle.
- PWM counter `cnt`, 8 bits, increments on tick, wraps 0xFF→0x00. No saturation.
- Shadow duty `duty_q`:
  - Loaded from pwm_duty_cycle on the tick that wraps cnt 0xFF→0x00.
  - Held constant otherwise.
  - A mid-period change of pwm_duty_cycle has no effect until the next wrap.
- PWM level `pwm` (combinational):
  - duty_q == 0xFF → 1 (true 100%).
  - Otherwise → (cnt < duty_q), unsigned 8-bit compare.
  - duty_q == 0x00 → constantly 0.
- Channel i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - en_out[i]=0 → out[i] next = 0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0 → out[i] next = 1.
  - en_out[i]=1, en_pwm[i]=1 → out[i] next = pwm.
- out is fully registered; no combinational path from any input to out.
- period_start is registered and asserted for exactly one clk, the cycle after the wrap tick (cnt==0x00 and duty_q newly loaded).

## Timing
- Reset (async assert, sync-released by the system): pre=0, cnt=0, duty_q=0x00, out=16'h0000, period_start=0.
- First duty load: at the first wrap, 256*CLK_DIV cycles after reset release. Until then all PWM channels output 0.
- Period: exactly 256*CLK_DIV clk cycles.
- High time per period: duty_q*CLK_DIV cycles, or the full period for 0xFF. The output rises at period start, coincident with period_start.
- Enable and mode changes: out reflects new en_out/en_pwm on the next rising clk edge (1-cycle latency), mid-period, with no waiting for the boundary.
- Simultaneous events:
  - A duty write on the same cycle as the wrap tick is captured (the new value is loaded).
  - Enable and mode changes on the wrap cycle use the new enables with the new duty.
- Reset mid-period: out drops to 0 immediately (asynchronous). Counters restart from 0 and duty_q returns to 0x00.

## Test plan
- Reset: hold rst_n=0 with all enables 0xFF and duty 0x80 → out=0x0000, period_start=0. After release, out=0x0000 for 256*13 cycles.
- Static: en_out=0x00FF, en_pwm=0x0000 → out=0x00FF one clk later. Then en_out=0xFF00 → out=0xFF00 one clk later.
- PWM 50%: en_out=en_pwm=0xFFFF, duty=0x80, CLK_DIV=13. After the first wrap, each period is 3328 cycles with 1664 high and 1664 low on all bits. period_start pulses every 3328 cycles.
- Extremes: duty=0x00 → all PWM channels constantly 0. duty=0xFF → constantly 1 across whole periods. duty=0x01 → high for 13 cycles per period.
- Mid-period duty change: duty 0x40→0xC0 at cnt=0x20 → the current period keeps 832-cycle high time. The next period has a 2496-cycle high time.
- Async reset at cnt=0x50 while outputs are high → out=0x0000 within the same cycle. After release, the first period_start comes after 3328 cycles.
